// File: rtl/pipe_stage_chain.sv
// ============================================================================
// Module   : pipe_stage_chain
// Brief    : DEPTH-stage valid/data pipeline with per-stage stall and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_chain #(
    parameter int                 WIDTH      = 64,
    parameter int                 DEPTH      = 4,
    parameter logic [WIDTH-1:0]   RESET_DATA = '0
) (
    input  logic                         CLK,
    input  logic                         resetl,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    input  logic [DEPTH-1:0]             stall_vec,
    input  logic [DEPTH-1:0]             flush_vec,
    output logic [DEPTH-1:0]             stage_valid,
    output logic [DEPTH*WIDTH-1:0]       stage_data,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  kill_cnt
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] w_hold;
    logic [DEPTH-1:0] w_nxt_valid;
    logic [WIDTH-1:0] w_nxt_data [DEPTH];
    logic [DEPTH-1:0] w_kill_mask;
    logic [CNT_W-1:0] w_kill_pop;
    logic [CNT_W-1:0] w_occ;
    logic [32:0]      w_kill_sum;
    logic [31:0]      r_stall_cnt;
    logic [31:0]      r_kill_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // A stall on any stage freezes that stage and everything upstream.
            assign w_hold[gi] = |stall_vec[DEPTH-1:gi];

            if (gi == 0) begin : g_first
                assign w_nxt_valid[gi] = w_hold[gi] ? r_valid[gi] : in_valid;
                assign w_nxt_data[gi]  = w_hold[gi] ? r_data[gi]  : in_data;
            end else begin : g_rest
                assign w_nxt_valid[gi] = w_hold[gi]   ? r_valid[gi]   :
                                         w_hold[gi-1] ? 1'b0          : r_valid[gi-1];
                assign w_nxt_data[gi]  = (w_hold[gi] || w_hold[gi-1]) ? r_data[gi] : r_data[gi-1];
            end

            assign stage_data[gi*WIDTH +: WIDTH] = r_data[gi];
        end
    endgenerate

    assign w_kill_mask = w_nxt_valid & flush_vec;

    always_comb begin
        w_kill_pop = '0;
        w_occ      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill_pop = w_kill_pop + CNT_W'(w_kill_mask[i]);
            w_occ      = w_occ + CNT_W'(r_valid[i]);
        end
    end

    assign w_kill_sum = {1'b0, r_kill_cnt} + 33'(w_kill_pop);

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
            r_kill_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_DATA;
            end
        end else begin
            r_valid <= w_nxt_valid & ~flush_vec;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_nxt_data[i];
            end
            if (in_valid && w_hold[0] && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            r_kill_cnt <= w_kill_sum[32] ? 32'hFFFF_FFFF : w_kill_sum[31:0];
        end
    end

    assign in_ready    = ~w_hold[0];
    assign stage_valid = r_valid;
    assign out_valid   = r_valid[DEPTH-1];
    assign out_data    = r_data[DEPTH-1];
    assign occupancy   = w_occ;
    assign stall_cnt   = r_stall_cnt;
    assign kill_cnt    = r_kill_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
// ============================================================================
// Module   : tb_pipe_stage_chain
// Brief    : Directed scoreboard bench for pipe_stage_chain (DEPTH=4, WIDTH=64).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_chain;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic                       CLK = 1'b0;
    logic                       resetl;
    logic                       in_valid;
    logic [WIDTH-1:0]           in_data;
    logic                       in_ready;
    logic [DEPTH-1:0]           stall_vec;
    logic [DEPTH-1:0]           flush_vec;
    logic [DEPTH-1:0]           stage_valid;
    logic [DEPTH*WIDTH-1:0]     stage_data;
    logic                       out_valid;
    logic [WIDTH-1:0]           out_data;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [31:0]                stall_cnt;
    logic [31:0]                kill_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q [$];

    pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DATA('0)) dut (
        .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall_vec(stall_vec), .flush_vec(flush_vec),
        .stage_valid(stage_valid), .stage_data(stage_data), .out_valid(out_valid),
        .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt),
        .kill_cnt(kill_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] sd(input int i);
        return stage_data[i*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Monitor: every presented output must match the head of the scoreboard.
    initial begin
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge CLK);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: got %h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with stall/flush/in_valid active: reset dominates.
        resetl = 1'b0; in_valid = 1'b1; in_data = 64'hAA;
        stall_vec = 4'b1000; flush_vec = 4'b1111;
        #1 chk("rst_in_ready_stalled", 64'(in_ready), 64'd0);
        tick(); tick();
        chk("rst_valid", 64'(stage_valid), 64'd0);
        for (int i = 0; i < DEPTH; i++) chk("rst_data", sd(i), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_kill_cnt", 64'(kill_cnt), 64'd0);
        stall_vec = '0; flush_vec = '0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("rst_no_capture", 64'(stage_valid), 64'd0);

        // Basic stream, latency DEPTH-1 edges after capture.
        resetl = 1'b1;
        exp_q.push_back(64'h10); exp_q.push_back(64'h20); exp_q.push_back(64'h30);
        in_data = 64'h10; tick();
        in_data = 64'h20; tick();
        in_data = 64'h30; tick();
        chk("stream_occ3", 64'(occupancy), 64'd3);
        chk("stream_not_yet_out", 64'(out_valid), 64'd0);
        in_valid = 1'b0; tick();
        chk("stream_occ3_b", 64'(occupancy), 64'd3);
        repeat (3) tick();
        chk("stream_drained", 64'(occupancy), 64'd0);

        // Fill 0x1..0x4, then stall stage 2 for one cycle.
        exp_q.push_back(64'h1);
        in_valid = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            in_data = 64'(v); tick();
        end
        stall_vec = 4'b0100; in_data = 64'h5;
        #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("stall_valid", 64'(stage_valid), 64'b0111);
        chk("stall_s0", sd(0), 64'h4);
        chk("stall_s1", sd(1), 64'h3);
        chk("stall_s2", sd(2), 64'h2);
        chk("stall_s3_data", sd(3), 64'h1);
        chk("stall_cnt1", 64'(stall_cnt), 64'd1);
        exp_q.push_back(64'h2);
        stall_vec = '0; tick();
        chk("resume_valid", 64'(stage_valid), 64'b1111);
        chk("resume_s0", sd(0), 64'h5);

        // Flush stages 0 and 1 on a full pipe.
        exp_q.push_back(64'h3); exp_q.push_back(64'h4);
        flush_vec = 4'b0011; in_data = 64'h6; tick();
        flush_vec = '0;
        chk("flush_valid", 64'(stage_valid), 64'b1100);
        chk("flush_kill_cnt", 64'(kill_cnt), 64'd2);
        chk("flush_s0_data", sd(0), 64'h6);
        chk("flush_s1_data", sd(1), 64'h5);

        // Refill, then stall+flush stage 1 together.
        exp_q.push_back(64'h7); exp_q.push_back(64'h8);
        in_data = 64'h7; tick();
        in_data = 64'h8; tick();
        in_data = 64'h9; tick();
        in_data = 64'hA; tick();
        chk("refill_valid", 64'(stage_valid), 64'b1111);
        stall_vec = 4'b0010; flush_vec = 4'b0010; in_data = 64'hB; tick();
        stall_vec = '0; flush_vec = '0;
        chk("sf_valid", 64'(stage_valid), 64'b1001);
        chk("sf_s0", sd(0), 64'hA);
        chk("sf_s1_held", sd(1), 64'h9);
        chk("sf_s2_bubble", sd(2), 64'h8);
        chk("sf_s3", sd(3), 64'h8);
        chk("sf_kill_cnt", 64'(kill_cnt), 64'd3);
        chk("sf_stall_cnt", 64'(stall_cnt), 64'd2);

        // Reset mid-stream with a stall active.
        resetl = 1'b0; stall_vec = 4'b0100; in_data = 64'hC; tick();
        chk("mrst_valid", 64'(stage_valid), 64'd0);
        for (int i = 0; i < DEPTH; i++) chk("mrst_data", sd(i), 64'd0);
        chk("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("mrst_kill_cnt", 64'(kill_cnt), 64'd0);
        resetl = 1'b1; stall_vec = '0; in_data = 64'hD;
        exp_q.push_back(64'hD);
        tick();
        in_valid = 1'b0; tick(); tick();
        chk("mrst_latency", 64'(out_valid), 64'd0);
        tick(); tick();

        // Counter saturation and all-stall hold with flush.
        in_valid = 1'b1; in_data = 64'hE; tick();
        in_data = 64'hF; tick();
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1 release dut.r_stall_cnt;
        chk("sat_preload", 64'(stall_cnt), 64'hFFFF_FFFE);
        stall_vec = 4'b1111; in_data = 64'h99;
        #1 chk("allstall_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("allstall_valid", 64'(stage_valid), 64'b0011);
        chk("allstall_s0", sd(0), 64'hF);
        chk("allstall_s1", sd(1), 64'hE);
        chk("sat_cnt1", 64'(stall_cnt), 64'hFFFF_FFFF);
        flush_vec = 4'b0001; tick();
        flush_vec = '0;
        chk("allstall_flush_valid", 64'(stage_valid), 64'b0010);
        chk("allstall_flush_data", sd(0), 64'hF);
        chk("allstall_kill_cnt", 64'(kill_cnt), 64'd1);
        chk("sat_cnt2", 64'(stall_cnt), 64'hFFFF_FFFF);
        tick();
        chk("sat_cnt3", 64'(stall_cnt), 64'hFFFF_FFFF);
        exp_q.push_back(64'hE);
        stall_vec = '0; in_valid = 1'b0;
        repeat (4) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter WIDTH, default 64, payload bits carried per stage.
REQ-002 Parameter DEPTH, default 4, number of pipeline register stages (2..16); stage 0 is nearest input, stage DEPTH-1 drives output.
REQ-003 Parameter RESET_DATA, default 0, WIDTH-bit value loaded into every stage data register on reset.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 resetl  input  1  reset; synchronous, active-low.
REQ-006 in_valid  input  1  upstream entry present on in_data.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  stage 0 will capture this cycle.
REQ-009 stall_vec  input  DEPTH  bit i requests stage i hold its contents.
REQ-010 flush_vec  input  DEPTH  bit i kills the entry stage i holds after this edge.
REQ-011 stage_valid  output  DEPTH  registered valid bit per stage.
REQ-012 stage_data  output  DEPTH*WIDTH  registered payload per stage, stage i at bits [i*WIDTH +: WIDTH].
REQ-013 out_valid  output  1  equals stage_valid[DEPTH-1].
REQ-014 out_data  output  WIDTH  equals payload of stage DEPTH-1.
REQ-015 occupancy  output  $clog2(DEPTH+1)  popcount of stage_valid, combinational from registers.
REQ-016 stall_cnt  output  32  cycles with in_valid=1 and in_ready=0.
REQ-017 kill_cnt  output  32  valid entries destroyed by flush.

Function
REQ-018 Effective hold h[DEPTH-1]=stall_vec[DEPTH-1]; h[i]=stall_vec[i] | h[i+1] for i<DEPTH-1 (a stall freezes its stage and all upstream stages).
REQ-019 in_ready SHALL equal !h[0], combinational, independent of in_valid.
REQ-020 Stage 0, !h[0]: load in_data and in_valid; h[0]: keep data and valid.
REQ-021 Stage i>0, !h[i] and !h[i-1]: load data and valid from stage i-1.
REQ-022 Stage i>0, !h[i] and h[i-1]: insert bubble -- valid 0, data unchanged.
REQ-023 Stage i, h[i]: keep data and valid.
REQ-024 flush_vec[i]=1 SHALL force stage i valid to 0 after the edge, overriding REQ-020..023; data follows REQ-020..023 unchanged.
REQ-025 Latency: entry accepted (in_valid & in_ready) at edge n appears on out_valid/out_data after edge n+DEPTH-1 if no hold or flush occurs meanwhile; throughput one entry per cycle.
REQ-026 Last stage consumed every cycle it is not held; no downstream handshake exists.
REQ-027 Invalid entries move like valid ones; stall and flush act regardless of stage_valid.
REQ-028 stall_cnt increments by 1 when in_valid & !in_ready; saturates at 32'hFFFF_FFFF, never wraps.
REQ-029 kill_cnt increments by popcount of the stage valid values that would result without flush, masked by flush_vec; saturates at 32'hFFFF_FFFF.
REQ-030 Flush and stall on the same stage same cycle: valid 0, data held, all upstream stages held.
REQ-031 All stall_vec bits 1: every stage holds; in_ready=0; flushes still apply.

Reset
REQ-032 resetl=0 at an edge: every stage_valid 0, every stage data RESET_DATA, stall_cnt 0, kill_cnt 0; dominates stall and flush.
REQ-033 During reset in_ready follows REQ-019; entries presented are not captured that edge.
REQ-034 Reset asserted mid-stream discards all in-flight entries; first post-reset entry sees full REQ-025 latency.

Verification (DEPTH=4, WIDTH=64)
REQ-035 Reset, then stream 0x10,0x20,0x30 one per cycle, no stalls -> out_data 0x10 with out_valid=1 after 4th capturing edge, then 0x20, 0x30 consecutively; occupancy reaches 3.
REQ-036 Pipe full (0x1..0x4, stage0=0x4), stall_vec=4'b0100 one cycle, in_valid=1 -> stages 0..2 unchanged, stage3 valid 0, in_ready=0, stall_cnt=1; resumes next cycle.
REQ-037 Pipe full, flush_vec=4'b0011 one cycle, no stall -> stage_valid=4'b1100 after the edge (stages 0,1 invalid, 2,3 hold shifted entries); kill_cnt=2.
REQ-038 stall_vec=4'b0010 and flush_vec=4'b0010 together on full pipe -> stage1 valid 0 with data held, stage0 held, stage2 bubble, stage3 advanced.
REQ-039 resetl low one cycle mid-stream with stalls active -> all valid 0, stage data RESET_DATA, both counters 0 after that edge.
REQ-040 stall_cnt forced to 32'hFFFF_FFFE, two stalled valid cycles -> reads 32'hFFFF_FFFF and stays there.
